// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_port_arbiter.
// slave = arbiter view, master = environment (requesters + SRAM) view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_rvalid0;
  logic              o_rvalid1;
  logic [DATA_W-1:0] o_rdata0;
  logic [DATA_W-1:0] o_rdata1;
  logic              o_busy;
  logic [ADDR_W-1:0] o_s_addr;
  logic [DATA_W-1:0] o_s_data;
  logic              o_s_wen;
  logic [DATA_W-1:0] i_s_data;

  modport slave (
    input  i_req0, i_req1,
    input  i_we0, i_we1,
    input  i_addr0, i_addr1,
    input  i_wdata0, i_wdata1,
    input  i_s_data,
    output o_gnt0, o_gnt1,
    output o_rvalid0, o_rvalid1,
    output o_rdata0, o_rdata1,
    output o_busy,
    output o_s_addr, o_s_data,
    output o_s_wen
  );

  modport master (
    output i_req0, i_req1,
    output i_we0, i_we1,
    output i_addr0, i_addr1,
    output i_wdata0, i_wdata1,
    output i_s_data,
    input  o_gnt0, o_gnt1,
    input  o_rvalid0, o_rvalid1,
    input  o_rdata0, o_rdata1,
    input  o_busy,
    input  o_s_addr, o_s_data,
    input  o_s_wen
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port SRAM with
// fixed read latency, write hold and one turnaround cycle.
module sram_port_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 2,
  parameter int WR_HOLD = 2
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  sram_port_arbiter_if.slave  bus
);
  localparam int MAX_LAT =
    (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_TURN
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              sel;
  logic              any_req;
  logic [CNT_W-1:0]  lat_m1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = wen_q;
    any_req = bus.i_req0 | bus.i_req1;
    // Only a tie consults the pointer.
    sel = (bus.i_req0 & bus.i_req1) ?
          ptr_q : bus.i_req1;
    // The live o_s_wen tells write from read.
    lat_m1 = wen_q ? CNT_W'(WR_HOLD - 1)
                   : CNT_W'(RD_LAT - 1);
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = sel;
          ptr_d   = ~sel;
          cnt_d   = '0;
          state_d = S_ACCESS;
          if (sel) begin
            addr_d = bus.i_addr1;
            data_d = bus.i_wdata1;
            wen_d  = bus.i_we1;
            gnt1_d = 1'b1;
          end else begin
            addr_d = bus.i_addr0;
            data_d = bus.i_wdata0;
            wen_d  = bus.i_we0;
            gnt0_d = 1'b1;
          end
        end else begin
          wen_d = 1'b0;
        end
      end
      S_ACCESS: begin
        if (cnt_q == lat_m1) begin
          wen_d   = 1'b0;
          state_d = S_TURN;
          if (!wen_q) begin
            if (win_q) begin
              rd1_d = bus.i_s_data;
              rv1_d = 1'b1;
            end else begin
              rd0_d = bus.i_s_data;
              rv0_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_gnt0    = gnt0_q;
  assign bus.o_gnt1    = gnt1_q;
  assign bus.o_rvalid0 = rv0_q;
  assign bus.o_rvalid1 = rv1_q;
  assign bus.o_rdata0  = rd0_q;
  assign bus.o_rdata1  = rd1_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_s_addr  = addr_q;
  assign bus.o_s_data  = data_q;
  assign bus.o_s_wen   = wen_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small
// behavioural SRAM model (addresses folded to 10 bits).
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_port_arbiter #(
    .ADDR_W(20), .DATA_W(16),
    .RD_LAT(2), .WR_HOLD(2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  logic [15:0] mem [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a  = '0;
  logic [15:0] pl_d  = '0;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_a] <= pl_d;
    else if (bus.o_s_wen)
      mem[bus.o_s_addr[9:0]] <= bus.o_s_data;
  end
  assign bus.i_s_data = mem[bus.o_s_addr[9:0]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.i_req0 = 0; bus.i_we0 = 0;
    bus.i_addr0 = '0; bus.i_wdata0 = '0;
    bus.i_req1 = 0; bus.i_we1 = 0;
    bus.i_addr1 = '0; bus.i_wdata1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clr_in();
    tick();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [5:0] ctl();
    return {bus.o_gnt0, bus.o_gnt1,
            bus.o_rvalid0, bus.o_rvalid1,
            bus.o_s_wen, bus.o_busy};
  endfunction

  task automatic access(input int who,
                        input logic we,
                        input logic [19:0] a,
                        input logic [15:0] d,
                        output logic [15:0] rd);
    logic got;
    rd = '0;
    if (who == 1) begin
      bus.i_req1 = 1; bus.i_we1 = we;
      bus.i_addr1 = a; bus.i_wdata1 = d;
    end else begin
      bus.i_req0 = 1; bus.i_we0 = we;
      bus.i_addr0 = a; bus.i_wdata0 = d;
    end
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = (who == 1) ? bus.o_gnt1 : bus.o_gnt0;
    end
    chk("acc_gnt", 64'(got), 64'd1);
    clr_in();
    if (!we) begin
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        tick();
        got = (who == 1) ? bus.o_rvalid1
                         : bus.o_rvalid0;
      end
      chk("acc_rvalid", 64'(got), 64'd1);
      rd = (who == 1) ? bus.o_rdata1 : bus.o_rdata0;
    end
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = !bus.o_busy;
    end
    chk("acc_idle", 64'(got), 64'd1);
  endtask

  typedef struct {
    logic        r0;
    logic        w0;
    logic [19:0] a0;
    logic [15:0] d0;
    logic        r1;
    logic        w1;
    logic [19:0] a1;
    logic [15:0] d1;
    logic [5:0]  eo;
    logic [19:0] ea;
    logic [15:0] ed;
    logic [15:0] er1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int last_t;
    int n;
    int both;
    int gt [$];
    int gw [$];
    logic [15:0] rd;

    // eo = {gnt0, gnt1, rvalid0, rvalid1, s_wen, busy}
    vecs[0] = '{1, 1, 20'h10, 16'hABCD, 0, 0, 0, 0,
                6'b100011, 20'h10, 16'hABCD, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000011, 20'h10, 16'hABCD, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000001, 20'h10, 16'hABCD, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000000, 20'h10, 16'hABCD, 0};
    vecs[4] = '{0, 0, 0, 0, 1, 0, 20'h20, 0,
                6'b010001, 20'h20, 16'h0, 0};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000001, 20'h20, 16'h0, 0};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000101, 20'h20, 16'h0, 16'h1234};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000000, 20'h20, 16'h0, 16'h1234};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0,
                6'b000000, 20'h20, 16'h0, 16'h1234};

    clr_in();
    pl_en = 1; pl_a = 10'h20; pl_d = 16'h1234;
    do_reset();
    pl_en = 0;

    chk("rst_ctl", 64'(ctl()), 64'd0);
    chk("rst_dat", 64'({bus.o_rdata0, bus.o_rdata1,
                        bus.o_s_data}), 64'd0);
    chk("rst_addr", 64'(bus.o_s_addr), 64'd0);

    // Single write, then single read, cycle by cycle.
    for (int i = 0; i < 9; i++) begin
      bus.i_req0 = vecs[i].r0;
      bus.i_we0 = vecs[i].w0;
      bus.i_addr0 = vecs[i].a0;
      bus.i_wdata0 = vecs[i].d0;
      bus.i_req1 = vecs[i].r1;
      bus.i_we1 = vecs[i].w1;
      bus.i_addr1 = vecs[i].a1;
      bus.i_wdata1 = vecs[i].d1;
      tick();
      chk($sformatf("v%0d_ctl", i),
          64'(ctl()), 64'(vecs[i].eo));
      chk($sformatf("v%0d_addr", i),
          64'(bus.o_s_addr), 64'(vecs[i].ea));
      chk($sformatf("v%0d_data", i),
          64'(bus.o_s_data), 64'(vecs[i].ed));
      chk($sformatf("v%0d_rd1", i),
          64'(bus.o_rdata1), 64'(vecs[i].er1));
    end
    chk("mem_10", 64'(mem[10'h10]), 64'hABCD);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    bus.i_req0 = 1; bus.i_addr0 = 20'h1;
    bus.i_req1 = 1; bus.i_addr1 = 20'h2;
    both = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (bus.o_gnt0 && bus.o_gnt1) both++;
      if (bus.o_gnt0 || bus.o_gnt1) begin
        gt.push_back(t);
        gw.push_back(bus.o_gnt1 ? 1 : 0);
      end
    end
    clr_in();
    chk("cont_both", 64'(both), 64'd0);
    chk("cont_n", 64'(gt.size()), 64'd4);
    for (int i = 0; i < gt.size() && i < 4; i++) begin
      chk($sformatf("cont_t%0d", i),
          64'(gt[i]), 64'(4 * i));
      chk($sformatf("cont_w%0d", i),
          64'(gw[i]), 64'(i % 2));
    end
    for (int k = 0; k < 4; k++) tick();

    // Back-to-back writes from requester 0.
    n = 0;
    last_t = 0;
    bus.i_req0 = 1; bus.i_we0 = 1;
    bus.i_addr0 = 20'd0; bus.i_wdata0 = 16'hC000;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.o_gnt0) begin
        if (n == 0)
          chk("b2b_first", 64'(t), 64'd0);
        else
          chk($sformatf("b2b_gap%0d", n),
              64'(t - last_t), 64'd4);
        last_t = t;
        n++;
        if (n < 8) begin
          bus.i_addr0 = 20'(n);
          bus.i_wdata0 = 16'hC000 + 16'(n);
        end else begin
          bus.i_req0 = 0;
        end
      end
    end
    clr_in();
    chk("b2b_n", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b2b_mem%0d", i),
          64'(mem[i]), 64'(16'hC000 + 16'(i)));

    // Read-after-write across requesters at top address.
    access(0, 1'b1, 20'hFFFFF, 16'h5A5A, rd);
    access(1, 1'b0, 20'hFFFFF, 16'h0, rd);
    chk("raw_rd1", 64'(rd), 64'h5A5A);

    // Reset one cycle into a read.
    bus.i_req1 = 1; bus.i_we1 = 0;
    bus.i_addr1 = 20'h20;
    tick();
    chk("mid_gnt1", 64'(bus.o_gnt1), 64'd1);
    clr_in();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_ctl", 64'(ctl()), 64'd0);
    chk("mid_dat", 64'({bus.o_rdata0, bus.o_rdata1,
                        bus.o_s_data}), 64'd0);
    chk("mid_addr", 64'(bus.o_s_addr), 64'd0);
    tick();
    chk("mid_norv", 64'(ctl()), 64'd0);
    bus.i_req0 = 1; bus.i_req1 = 1;
    bus.i_addr0 = 20'h5; bus.i_addr1 = 20'h6;
    tick();
    chk("mid_regnt", 64'({bus.o_gnt0, bus.o_gnt1}),
        64'b10);
    clr_in();
    for (int k = 0; k < 4; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
